// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with edge- or center-aligned counting and
// double-buffered period/duty/mode that switch over only at period boundaries.
module pwm_multi #(
    parameter int CBITS = 15,
    parameter int NCH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [CBITS-1:0]     period,
    input  logic [NCH*CBITS-1:0] duty,
    input  logic                 load,
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_start,
    output logic                 load_ack
);

    typedef enum logic {UP, DOWN} dir_t;

    localparam logic [CBITS-1:0] ONE = CBITS'(1);

    dir_t                 state, state_nxt;
    logic [CBITS-1:0]     cnt, cnt_nxt;
    logic [CBITS-1:0]     act_period, pend_period;
    logic [NCH*CBITS-1:0] act_duty, pend_duty;
    logic                 act_mode, pend_mode, pend;
    logic                 boundary, xfer;
    logic [NCH-1:0]       pwm_nxt;
    logic [CBITS-1:0]     duty_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        boundary  = 1'b0;
        // Center mode wraps on DOWN@1; with period 1 the UP peak is the wrap point.
        if (act_period == '0)
            boundary = 1'b1;
        else if (!act_mode)
            boundary = (cnt == act_period - ONE);
        else if (state == DOWN)
            boundary = (cnt == ONE);
        else
            boundary = (cnt == act_period) && (act_period == ONE);
        boundary = boundary & en;
        xfer     = pend & (boundary | ~en);

        if (!en || boundary) begin
            cnt_nxt   = '0;
            state_nxt = UP;
        end else if (!act_mode) begin
            cnt_nxt = cnt + ONE;
        end else if (state == UP) begin
            if (cnt == act_period) begin
                state_nxt = DOWN;
                cnt_nxt   = cnt - ONE;
            end else begin
                cnt_nxt = cnt + ONE;
            end
        end else begin
            cnt_nxt = cnt - ONE;
        end
    end

    always_comb begin
        pwm_nxt = '0;
        duty_i  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            duty_i     = act_duty[i*CBITS +: CBITS];
            // duty >= period also covers the center-mode peak where cnt == period
            pwm_nxt[i] = en && (act_period != '0) &&
                         ((cnt < duty_i) || (duty_i >= act_period));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UP;
            cnt         <= '0;
            pwm_out     <= '0;
            load_ack    <= 1'b0;
            act_period  <= '0;
            act_duty    <= '0;
            act_mode    <= 1'b0;
            pend_period <= '0;
            pend_duty   <= '0;
            pend_mode   <= 1'b0;
            pend        <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pwm_out  <= pwm_nxt;
            load_ack <= xfer;
            if (xfer) begin
                act_period <= pend_period;
                act_duty   <= pend_duty;
                act_mode   <= pend_mode;
            end
            if (load) begin
                pend_period <= period;
                pend_duty   <= duty;
                pend_mode   <= mode;
            end
            pend <= load | (pend & ~xfer);
        end
    end

    assign period_start = en & ~rst & (cnt == '0);

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a phase-position reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_multi;
    localparam int CBITS = 15;
    localparam int NCH   = 3;

    logic                 clk = 1'b0;
    logic                 rst, en, mode, load;
    logic [CBITS-1:0]     period;
    logic [NCH*CBITS-1:0] duty;
    logic [NCH-1:0]       pwm_out;
    logic                 period_start, load_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CBITS(CBITS), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period),
        .duty(duty), .load(load), .pwm_out(pwm_out),
        .period_start(period_start), .load_ack(load_ack)
    );

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: position within the period, counter value derived from it.
    int unsigned    m_p = 0, m_pp = 0, m_pos = 0;
    int unsigned    m_d [NCH];
    int unsigned    m_pd[NCH];
    bit             m_mode = 0, m_pmode = 0, m_pend = 0, m_ack = 0;
    bit [NCH-1:0]   m_pwm = '0;

    function automatic int unsigned m_cnt();
        if (!m_mode) return m_pos;
        return (m_pos <= m_p) ? m_pos : 2 * m_p - m_pos;
    endfunction

    always @(posedge clk or posedge rst) begin
        int unsigned c, len;
        bit bnd, xf;
        if (rst) begin
            m_p = 0; m_pp = 0; m_pos = 0; m_mode = 0; m_pmode = 0;
            m_pend = 0; m_ack = 0; m_pwm = '0;
            for (int i = 0; i < NCH; i++) begin m_d[i] = 0; m_pd[i] = 0; end
        end else begin
            c   = m_cnt();
            len = m_mode ? 2 * m_p : m_p;
            bnd = en && (m_p == 0 || m_pos == len - 1);
            xf  = m_pend && (bnd || !en);
            for (int i = 0; i < NCH; i++)
                m_pwm[i] = en && m_p != 0 && (c < m_d[i] || m_d[i] >= m_p);
            m_ack = xf;
            if (!en || bnd) m_pos = 0; else m_pos++;
            if (xf) begin
                m_p = m_pp; m_mode = m_pmode;
                for (int i = 0; i < NCH; i++) m_d[i] = m_pd[i];
            end
            if (load) begin
                m_pp = period; m_pmode = mode;
                for (int i = 0; i < NCH; i++) m_pd[i] = duty[i*CBITS +: CBITS];
            end
            m_pend = load || (m_pend && !xf);
        end
    end

    always @(negedge clk) begin
        chk("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
        chk("model_load_ack", 32'(load_ack), 32'(m_ack));
        chk("model_period_start", 32'(period_start),
            32'(en && !rst && m_cnt() == 0));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int p, input int d0, input int d1, input int d2, input bit md);
        period = CBITS'(p);
        duty   = {CBITS'(d2), CBITS'(d1), CBITS'(d0)};
        mode   = md;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_ps(input int maxc, input string name);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (period_start) found = 1;
        end
        chk(name, 32'(found), 1);
    endtask

    task automatic wait_ack(input int maxc, input string name);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (load_ack) found = 1;
        end
        chk(name, 32'(found), 1);
    endtask

    task automatic measure(input int n, output int h0, output int h1, output int h2,
                           output int ps, output int acks);
        h0 = 0; h1 = 0; h2 = 0; ps = 0; acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            ps += int'(period_start);
            acks += int'(load_ack);
        end
    endtask

    initial begin
        int h0, h1, h2, ps, acks, gap;
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; period = '0; duty = '0;
        repeat (3) tick();
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_ack", 32'(load_ack), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_pwm", 32'(pwm_out), 0);

        // Load while disabled: transfer without a boundary.
        do_load(10, 3, 0, 10, 1'b0);
        chk("ack_not_yet", 32'(load_ack), 0);
        tick();
        chk("ack_en0", 32'(load_ack), 1);
        tick();
        chk("ack_one_cycle", 32'(load_ack), 0);

        // Edge mode, period 10, duties 3/0/10.
        en = 1'b1;
        #1;
        chk("ps_first_cycle", 32'(period_start), 1);
        chk("pwm_first_cycle", 32'(pwm_out), 0);
        repeat (10) @(negedge clk);
        measure(20, h0, h1, h2, ps, acks);
        chk("edge_ch0_high", h0, 6);
        chk("edge_ch1_high", h1, 0);
        chk("edge_ch2_high", h2, 20);
        chk("edge_ps_count", ps, 2);

        // Two loads in one period at counts 5 and 7; only the second applies.
        wait_ps(20, "sync_ps_a");
        repeat (5) tick();
        do_load(10, 7, 0, 10, 1'b0);
        tick();
        do_load(10, 4, 0, 10, 1'b0);
        chk("no_early_ack", 32'(load_ack), 0);
        wait_ps(20, "sync_ps_b");
        chk("ack_at_boundary", 32'(load_ack), 1);
        measure(10, h0, h1, h2, ps, acks);
        chk("last_load_ch0_high", h0, 4);
        chk("last_load_ch2_high", h2, 10);

        // Center mode, period 8.
        do_load(8, 4, 0, 8, 1'b1);
        wait_ack(30, "center_ack");
        measure(32, h0, h1, h2, ps, acks);
        chk("center_ps_count", ps, 2);
        chk("center_ch1_high", h1, 0);
        chk("center_ch2_high", h2, 32);
        wait_ps(20, "center_sync");
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (period_start) break;
        end
        chk("center_ps_gap", gap, 16);

        // Asynchronous reset at count 6 with a load pending.
        do_load(10, 3, 0, 10, 1'b0);
        wait_ack(40, "edge_back_ack");
        wait_ps(20, "sync_ps_c");
        repeat (5) tick();
        do_load(10, 5, 0, 10, 1'b0);
        chk("pre_rst_ch2", 32'(pwm_out[2]), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 0);
        chk("async_rst_ps", 32'(period_start), 0);
        chk("async_rst_ack", 32'(load_ack), 0);
        en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        measure(15, h0, h1, h2, ps, acks);
        chk("no_ack_after_rst", acks, 0);
        chk("quiet_after_rst", h0 + h1 + h2 + ps, 0);

        // Period 0 while running.
        tick();
        en = 1'b1;
        do_load(10, 3, 0, 10, 1'b0);
        wait_ack(10, "p10_ack");
        repeat (12) tick();
        do_load(0, 3, 0, 10, 1'b0);
        wait_ack(20, "p0_ack");
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("p0_ps", 32'(period_start), 1);
            chk("p0_pwm", 32'(pwm_out), 0);
        end

        // Disable and re-enable.
        do_load(10, 3, 0, 10, 1'b0);
        wait_ack(10, "p10b_ack");
        repeat (4) tick();
        en = 1'b0;
        #1;
        chk("en0_ps", 32'(period_start), 0);
        tick();
        chk("en0_pwm", 32'(pwm_out), 0);
        tick();
        en = 1'b1;
        #1;
        chk("reen_ps", 32'(period_start), 1);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
